// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Sequences one load-then-shift job on a downstream 4-bit shift register.
// A job is requested with START while idle. The job parameters are captured
// at that moment. The job then runs:
//    LOAD  : 1 cycle, parallel load of the captured data word
//    SHIFT : COUNT cycles, circular or serial shift in the captured direction
//    FIN   : 1 cycle, DONE pulse
// ABORT cancels a running job (LOAD/SHIFT) with no DONE pulse.
// RESET_N is synchronous and active-low.
//
// Optional feature (macro SHIFT_SEQ_CAPTURE_EN):
//    When defined, the block gains input Q (the shift register contents) and
//    output RESULT. RESULT captures Q at the edge that ends FIN. When the
//    macro is undefined, Q/RESULT and the capture register do not exist.
//
// Ports
//    CLK      in   1  clock, rising edge
//    RESET_N  in   1  synchronous active-low reset
//    START    in   1  job request, honoured only in IDLE
//    ABORT    in   1  cancel the running job; wins over START in IDLE
//    DATA_IN  in   4  word to load
//    COUNT    in   4  number of shift cycles (0..15)
//    DIR_IN   in   1  shift direction for the job
//    CIRC     in   1  1 = circular shift, 0 = serial shift
//    SER_IN   in   1  fill bit for serial shifts
//    Q        in   4  shift register contents (capture build only)
//    ENB      out  1  shift register enable
//    DIR      out  1  shift direction
//    S_IN     out  1  serial fill bit
//    MODO     out  2  00 serial, 01 circular, 10 load, 11 hold
//    D        out  4  parallel load word
//    BUSY     out  1  high in LOAD and SHIFT
//    DONE     out  1  one-cycle completion pulse (FIN)
//    RESULT   out  4  captured result (capture build only)
// -----------------------------------------------------------------------------
module shift_sequencer (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic [3:0] DATA_IN,
   input  logic [3:0] COUNT,
   input  logic       DIR_IN,
   input  logic       CIRC,
   input  logic       SER_IN,
`ifdef SHIFT_SEQ_CAPTURE_EN
   input  logic [3:0] Q,
   output logic [3:0] RESULT,
`endif
   output logic       ENB,
   output logic       DIR,
   output logic       S_IN,
   output logic [1:0] MODO,
   output logic [3:0] D,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [1:0] MODE_SERIAL   = 2'b00;
   localparam logic [1:0] MODE_CIRCULAR = 2'b01;
   localparam logic [1:0] MODE_LOAD     = 2'b10;
   localparam logic [1:0] MODE_HOLD     = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      FIN   = 2'b11
   } state_t;

   state_t     state_r;
   logic [3:0] cnt_r;    // remaining shift cycles, exits SHIFT when it reads 1
   logic       dir_r;    // captured job direction
   logic       circ_r;   // captured shift kind
   logic       ser_r;    // captured serial fill bit

   // Job FSM with all outputs registered alongside the state transition.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         dir_r   <= 1'b0;
         circ_r  <= 1'b0;
         ser_r   <= 1'b0;
         ENB     <= 1'b0;
         DIR     <= 1'b0;
         S_IN    <= 1'b0;
         MODO    <= MODE_HOLD;
         D       <= 4'b0000;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         // DONE is a single-cycle pulse; only the exit into FIN raises it.
         DONE <= 1'b0;
         case (state_r)
            IDLE: begin
               // ABORT beats START so a simultaneous request is dropped.
               if (START && !ABORT) begin
                  state_r <= LOAD;
                  cnt_r   <= COUNT;
                  dir_r   <= DIR_IN;
                  circ_r  <= CIRC;
                  ser_r   <= SER_IN;
                  D       <= DATA_IN;
                  ENB     <= 1'b1;
                  MODO    <= MODE_LOAD;
                  BUSY    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  ENB     <= 1'b0;
                  MODO    <= MODE_HOLD;
                  BUSY    <= 1'b0;
               end
            end

            LOAD: begin
               if (ABORT) begin
                  state_r <= IDLE;
                  ENB     <= 1'b0;
                  MODO    <= MODE_HOLD;
                  BUSY    <= 1'b0;
               end else if (cnt_r != 4'd0) begin
                  state_r <= SHIFT;
                  ENB     <= 1'b1;
                  DIR     <= dir_r;
                  S_IN    <= ser_r;
                  MODO    <= circ_r ? MODE_CIRCULAR : MODE_SERIAL;
                  BUSY    <= 1'b1;
               end else begin
                  // Zero-length job: straight to completion after the load.
                  state_r <= FIN;
                  ENB     <= 1'b0;
                  MODO    <= MODE_HOLD;
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
               end
            end

            SHIFT: begin
               // ABORT is tested first so it wins over counter expiry.
               if (ABORT) begin
                  state_r <= IDLE;
                  ENB     <= 1'b0;
                  MODO    <= MODE_HOLD;
                  BUSY    <= 1'b0;
               end else if (cnt_r == 4'd1) begin
                  state_r <= FIN;
                  cnt_r   <= 4'd0;
                  ENB     <= 1'b0;
                  MODO    <= MODE_HOLD;
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
               end else begin
                  state_r <= SHIFT;
                  cnt_r   <= cnt_r - 4'd1;
                  ENB     <= 1'b1;
                  MODO    <= circ_r ? MODE_CIRCULAR : MODE_SERIAL;
                  BUSY    <= 1'b1;
               end
            end

            FIN: begin
               // START here is deliberately ignored; restart is from IDLE.
               state_r <= IDLE;
               ENB     <= 1'b0;
               MODO    <= MODE_HOLD;
               BUSY    <= 1'b0;
            end

            default: begin
               state_r <= IDLE;
               ENB     <= 1'b0;
               MODO    <= MODE_HOLD;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHIFT_SEQ_CAPTURE_EN
   // Result capture: Q during FIN already holds the post-final-shift word.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         RESULT <= 4'b0000;
      end else if (state_r == FIN) begin
         RESULT <= Q;
      end else begin
         RESULT <= RESULT;
      end
   end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Stimulus issues jobs (directed, then randomized) and pushes one expected
// job record per accepted START into a queue. A separate monitor watches the
// DUT outputs every cycle, reconstructs each job from the ENB/MODO stream and
// compares it against the popped record when the job ends.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       START;
   logic       ABORT;
   logic [3:0] DATA_IN;
   logic [3:0] COUNT;
   logic       DIR_IN;
   logic       CIRC;
   logic       SER_IN;
   logic       ENB;
   logic       DIR;
   logic       S_IN;
   logic [1:0] MODO;
   logic [3:0] D;
   logic       BUSY;
   logic       DONE;
`ifdef SHIFT_SEQ_CAPTURE_EN
   logic [3:0] Q;
   logic [3:0] RESULT;
   logic [3:0] sr_q = 4'b0000;   // downstream shift register model
   logic [3:0] exp_res = 4'b0000;
`endif

   shift_sequencer dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .START   (START),
      .ABORT   (ABORT),
      .DATA_IN (DATA_IN),
      .COUNT   (COUNT),
      .DIR_IN  (DIR_IN),
      .CIRC    (CIRC),
      .SER_IN  (SER_IN),
`ifdef SHIFT_SEQ_CAPTURE_EN
      .Q       (Q),
      .RESULT  (RESULT),
`endif
      .ENB     (ENB),
      .DIR     (DIR),
      .S_IN    (S_IN),
      .MODO    (MODO),
      .D       (D),
      .BUSY    (BUSY),
      .DONE    (DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         load_cyc;
      logic [3:0] d;
      int         nshift;
      logic       circ;
      logic       dir;
      logic       ser;
      bit         done;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   bit         mon_en = 1'b0;
   logic [3:0] exp_d = 4'b0000;

   always @(posedge CLK) cyc <= cyc + 1;

`ifdef SHIFT_SEQ_CAPTURE_EN
   // Downstream register: DIR=1 shifts toward the MSB.
   always @(posedge CLK) begin
      if (ENB) begin
         case (MODO)
            2'b10:   sr_q <= D;
            2'b01:   sr_q <= DIR ? {sr_q[2:0], sr_q[3]} : {sr_q[0], sr_q[3:1]};
            2'b00:   sr_q <= DIR ? {sr_q[2:0], S_IN} : {S_IN, sr_q[3:1]};
            default: sr_q <= sr_q;
         endcase
      end
   end
   assign Q = sr_q;
`endif

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected final register word, from plain rotate/shift arithmetic.
   function automatic logic [3:0] ref_result(input logic [3:0] d, input int n,
                                             input logic dr, input logic ci, input logic se);
      logic [7:0] t;
      logic [3:0] fill;
      int         k;
      fill = se ? 4'hF : 4'h0;
      if (ci) begin
         k = dr ? (n % 4) : ((4 - (n % 4)) % 4);
         t = {d, d} << k;
         return t[7:4];
      end
      if (n >= 4) return fill;
      if (dr) t = ({4'b0000, d} << n) | ({4'b0000, fill} >> (4 - n));
      else    t = ({4'b0000, d} >> n) | ({4'b0000, fill} << (4 - n));
      return t[3:0];
   endfunction

   // ---------------- monitor ----------------
   bit  in_job = 1'b0;
   int  mon_load_cyc = 0;
   int  nsh = 0;

   always @(negedge CLK) begin
      exp_t e;
      if (mon_en) begin
         chk4("busy", {3'b000, BUSY}, {3'b000, ENB});
         chk4("d_value", D, exp_d);
`ifdef SHIFT_SEQ_CAPTURE_EN
         chk4("result", RESULT, exp_res);
`endif
         if (!ENB) chk4("modo_idle", {2'b00, MODO}, 4'b0011);
         else      chk4("done_while_enb", {3'b000, DONE}, 4'b0000);
         if (in_job) begin
            if (ENB) begin
               nsh++;
               if (exp_q.size() > 0) begin
                  chk4("modo_shift", {2'b00, MODO}, exp_q[0].circ ? 4'b0001 : 4'b0000);
                  chk4("dir", {3'b000, DIR}, {3'b000, exp_q[0].dir});
                  chk4("s_in", {3'b000, S_IN}, {3'b000, exp_q[0].ser});
               end
            end else begin
               in_job = 1'b0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_job: job loaded at cycle %0d, expected none", mon_load_cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk_int("load_cycle", mon_load_cyc, e.load_cyc);
                  chk_int("shift_cycles", nsh, e.nshift);
                  chk_int("end_cycle", cyc, e.load_cyc + 1 + e.nshift);
                  chk4("done", {3'b000, DONE}, {3'b000, e.done});
               end
            end
         end else if (ENB) begin
            chk4("modo_load", {2'b00, MODO}, 4'b0010);
            in_job       = 1'b1;
            mon_load_cyc = cyc;
            nsh          = 0;
         end else begin
            chk4("done_idle", {3'b000, DONE}, 4'b0000);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic scramble();
      DATA_IN = 4'($urandom_range(0, 15));
      COUNT   = 4'($urandom_range(0, 15));
      DIR_IN  = 1'($urandom_range(0, 1));
      CIRC    = 1'($urandom_range(0, 1));
      SER_IN  = 1'($urandom_range(0, 1));
   endtask

   task automatic check_reset_vals();
      chk4("rst_enb",  {3'b000, ENB},  4'b0000);
      chk4("rst_dir",  {3'b000, DIR},  4'b0000);
      chk4("rst_s_in", {3'b000, S_IN}, 4'b0000);
      chk4("rst_modo", {2'b00, MODO},  4'b0011);
      chk4("rst_d",    D,              4'b0000);
      chk4("rst_busy", {3'b000, BUSY}, 4'b0000);
      chk4("rst_done", {3'b000, DONE}, 4'b0000);
`ifdef SHIFT_SEQ_CAPTURE_EN
      chk4("rst_result", RESULT, 4'b0000);
`endif
   endtask

   task automatic idle(input int n, input bit both);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         scramble();
         START = both;
         ABORT = both;
         @(posedge CLK);
         #1;
      end
   endtask

   // One job: abort_at / rst_at give the job cycle (0 = LOAD) in which ABORT
   // or RESET_N is applied, -1 for none. hold keeps START high throughout.
   task automatic issue(input logic [3:0] d, input logic [3:0] c, input logic dr,
                        input logic ci, input logic se, input int abort_at,
                        input int rst_at, input bit hold);
      exp_t e;
      bit   stopped;
      @(negedge CLK);
      DATA_IN = d; COUNT = c; DIR_IN = dr; CIRC = ci; SER_IN = se;
      START = 1'b1; ABORT = 1'b0;
      @(posedge CLK);
      #1;
      e.load_cyc = cyc;
      e.d = d; e.circ = ci; e.dir = dr; e.ser = se;
      e.done   = (abort_at < 0) && (rst_at < 0);
      e.nshift = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : int'(c));
      exp_q.push_back(e);
      exp_d = d;
      stopped = 1'b0;
      for (int j = 0; j <= int'(c) && !stopped; j++) begin
         @(negedge CLK);
         scramble();
         START = hold ? 1'b1 : 1'($urandom_range(0, 1));
         ABORT = (j == abort_at);
         if (j == rst_at) RESET_N = 1'b0;
         @(posedge CLK);
         #1;
         if (j == abort_at) stopped = 1'b1;
         if (j == rst_at) begin
            stopped = 1'b1;
            exp_d = 4'b0000;
`ifdef SHIFT_SEQ_CAPTURE_EN
            exp_res = 4'b0000;
`endif
            @(negedge CLK);
            check_reset_vals();
            RESET_N = 1'b1;
            START = 1'b0;
            ABORT = 1'b0;
            @(posedge CLK);
            #1;
         end
      end
      if (!stopped) begin
         @(negedge CLK);              // FIN: START here must be ignored
         START = hold ? 1'b1 : 1'($urandom_range(0, 1));
         ABORT = 1'b0;
         @(posedge CLK);
         #1;
`ifdef SHIFT_SEQ_CAPTURE_EN
         exp_res = ref_result(d, int'(c), dr, ci, se);
`endif
      end
   endtask

   initial begin
      // Reset overrides START and ABORT.
      RESET_N = 1'b0; START = 1'b1; ABORT = 1'b1;
      scramble();
      @(posedge CLK);
      #1;
      mon_en = 1'b1;
      @(negedge CLK);
      check_reset_vals();
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check_reset_vals();
      RESET_N = 1'b1; START = 1'b0; ABORT = 1'b0;
      @(posedge CLK);
      #1;
      idle(2, 1'b0);

      issue(4'b0001, 4'd0,  1'b0, 1'b0, 1'b0, -1, -1, 1'b0);   // load only
      issue(4'b0001, 4'd10, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0);   // circular run
      issue(4'b1111, 4'd4,  1'b0, 1'b0, 1'b0, -1, -1, 1'b0);   // serial run
      issue(4'b1010, 4'd8,  1'b1, 1'b1, 1'b1,  3, -1, 1'b0);   // abort, 3rd SHIFT
      issue(4'b0110, 4'd5,  1'b0, 1'b1, 1'b0,  5, -1, 1'b0);   // abort on expiry
      issue(4'b1001, 4'd3,  1'b0, 1'b0, 1'b1,  0, -1, 1'b0);   // abort in LOAD
      idle(1, 1'b0);
      issue(4'b0111, 4'd8,  1'b0, 1'b0, 1'b1, -1,  3, 1'b0);   // reset mid-job
      issue(4'b1100, 4'd6,  1'b1, 1'b0, 1'b1, -1, -1, 1'b0);   // normal after reset
      issue(4'b0101, 4'd15, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1);   // START held
      issue(4'b0011, 4'd15, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);   // restart from IDLE
      idle(3, 1'b1);                                           // START+ABORT: no job

      for (int t = 0; t < 40; t++) begin
         logic [3:0] rd, rc;
         int         ab;
         rd = 4'($urandom_range(0, 15));
         rc = 4'($urandom_range(0, 15));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rc))) : -1;
         idle(int'($urandom_range(0, 3)), 1'b0);
         issue(rd, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ab, -1, 1'b0);
      end

      idle(3, 1'b0);
      chk_int("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port RESET_N, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port START, input, 1, request a load-then-shift job; sampled only in IDLE.
REQ-004 SHALL have port ABORT, input, 1, cancel the job in progress.
REQ-005 SHALL have port DATA_IN, input, 4, parallel word to load.
REQ-006 SHALL have port COUNT, input, 4, number of shift cycles, 0..15.
REQ-007 SHALL have port DIR_IN, input, 1, shift direction for the job.
REQ-008 SHALL have port CIRC, input, 1, shift kind: 1 = circular, 0 = serial.
REQ-009 SHALL have port SER_IN, input, 1, serial fill bit for serial shifts.
REQ-010 SHALL have ports ENB (1), DIR (1), S_IN (1), MODO (2) and D (4), all outputs and registered, driving the downstream 4-bit shift register.
REQ-011 SHALL have ports BUSY (output, 1, job active) and DONE (output, 1, one-cycle completion pulse).
REQ-012 MODO encoding SHALL be: 2'b00 serial shift, 2'b01 circular shift, 2'b10 parallel load, 2'b11 hold.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT and FIN.
REQ-014 In IDLE with START=1, the block SHALL latch DATA_IN, COUNT, DIR_IN, CIRC and SER_IN, and enter LOAD.
- Later changes to these inputs SHALL NOT affect the running job.
REQ-015 LOAD SHALL last exactly 1 cycle with ENB=1, MODO=2'b10, D=latched data.
- Next state: SHIFT if latched COUNT>0, else FIN.
REQ-016 SHIFT SHALL last exactly COUNT cycles with ENB=1, DIR=latched direction, MODO=2'b01 if CIRC else 2'b00, and S_IN=latched SER_IN.
- An internal 4-bit down-counter SHALL be loaded with COUNT; SHIFT exits to FIN when the counter reaches 1.
REQ-017 FIN SHALL last 1 cycle with DONE=1 and ENB=0, then go to IDLE.
REQ-018 In IDLE and FIN: ENB=0, MODO=2'b11; D and S_IN SHALL hold their last values.
REQ-019 BUSY SHALL be 1 in LOAD and SHIFT, and 0 otherwise.
REQ-020 Latency SHALL be: START sampled at edge k gives DONE high in the cycle after edge k+1+COUNT (COUNT+2 edges).
REQ-021 START while not in IDLE SHALL be ignored, with no queuing.
- START during FIN is ignored; the earliest accepted restart is in the IDLE cycle that follows.
REQ-022 ABORT=1 in LOAD or SHIFT SHALL force IDLE at the next edge: ENB=0, MODO=2'b11, no DONE pulse.
- ABORT SHALL have priority over counter expiry.
REQ-023 ABORT and START both high in IDLE: ABORT SHALL win and no job starts.
REQ-024 COUNT=15 SHALL produce exactly 15 SHIFT cycles; the counter SHALL NOT wrap into another pass.

Reset
REQ-025 RESET_N=0 at an edge SHALL force IDLE from any state, including mid-SHIFT, with no DONE pulse.
REQ-026 Reset values SHALL be: ENB=0, DIR=0, S_IN=0, MODO=2'b11, D=4'b0000, BUSY=0, DONE=0, counter=0, RESULT=4'b0000 (if present).
REQ-027 Reset SHALL override START and ABORT.

Configuration
REQ-028 Macro SHIFT_SEQ_CAPTURE_EN SHALL control result capture.
- Defined: adds input Q (4) from the shift register and output RESULT (4). RESULT is loaded from Q at the edge ending FIN (the post-final-shift contents) and holds until the next job's FIN or reset. Aborted jobs leave RESULT unchanged.
- Undefined: ports Q and RESULT are absent and no capture logic exists; all other behaviour is identical.

Verification
REQ-029 Load-only: DATA_IN=4'b0001, COUNT=0, START for 1 cycle -> one LOAD cycle (MODO=10, D=0001, ENB=1), then DONE on the next cycle; BUSY high for exactly 1 cycle.
REQ-030 Circular run: DATA_IN=0001, COUNT=10, CIRC=1, DIR_IN=1 -> 1 LOAD cycle plus 10 cycles of MODO=01, DIR=1, ENB=1; DONE 12 cycles after START; with the macro and a model register, RESULT=0100.
REQ-031 Serial run: DATA_IN=1111, COUNT=4, CIRC=0, SER_IN=0 -> 4 cycles of MODO=00, S_IN=0; with the macro, RESULT=0000.
REQ-032 Abort: COUNT=8, ABORT raised in the 3rd SHIFT cycle -> next cycle IDLE, ENB=0, MODO=11, no DONE, RESULT unchanged.
REQ-033 Reset mid-job: RESET_N=0 during SHIFT -> next cycle all outputs at reset values; a START issued after release runs a full job normally.
REQ-034 Busy/boundary: START held high through a COUNT=15 job -> exactly 15 SHIFT cycles; the second job starts in the IDLE cycle after FIN, not during FIN.
